// File: rtl/cv32e40p_ft_alu_fault_tracker_if.sv
// Bundle of control/status signals between the ALU voter logic and the
// fault tracker. The master drives voter results; the slave (tracker) returns
// the sticky fault vector and reconfiguration status.
interface cv32e40p_ft_alu_fault_tracker_if;
    logic       clear_i;
    logic       alu_valid_i;
    logic [3:0] active_alu_i;
    logic [3:0] alu_mismatch_i;
    logic [3:0] permanent_faulty_alu_o;
    logic       reconfig_o;
    logic       fault_event_o;
    logic       fatal_o;

    modport master (
        output clear_i, alu_valid_i, active_alu_i, alu_mismatch_i,
        input  permanent_faulty_alu_o, reconfig_o, fault_event_o, fatal_o
    );

    modport slave (
        input  clear_i, alu_valid_i, active_alu_i, alu_mismatch_i,
        output permanent_faulty_alu_o, reconfig_o, fault_event_o, fatal_o
    );
endinterface

// File: rtl/cv32e40p_ft_alu_fault_tracker.sv
// Fault tracker for the 4-replica ALU pool. Each ALU has a leaky saturating
// mismatch counter; reaching THRESH marks the ALU permanently faulty. A new
// fault opens a fixed-length reconfiguration window, or drops straight into
// the fatal state once two or more ALUs are faulty (TMR no longer possible).
module cv32e40p_ft_alu_fault_tracker #(
    parameter int CNT_W         = 4,
    parameter int THRESH        = 8,
    parameter int DECAY_PERIOD  = 1024,
    parameter int RECONF_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    cv32e40p_ft_alu_fault_tracker_if.slave    bus
);

    localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int TW = (RECONF_CYCLES > 1) ? $clog2(RECONF_CYCLES) : 1;

    localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] THRESH_M1   = CNT_W'(THRESH - 1);
    localparam logic [DW-1:0]    DECAY_LAST  = DW'(DECAY_PERIOD - 1);
    localparam logic [TW-1:0]    RECONF_LAST = TW'(RECONF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_MONITOR  = 2'd0,
        ST_RECONFIG = 2'd1,
        ST_FATAL    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       faulty_q, faulty_d;
    logic [DW-1:0]    decay_q, decay_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             event_q, event_d;

    logic [3:0]       counted;
    logic [3:0]       trip;
    logic             monitor;
    logic             tick;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Per-ALU counter update, trip detection and decay-period counter
    always_comb begin
        monitor  = (state_q == ST_MONITOR);
        counted  = {4{bus.alu_valid_i & monitor}} & bus.active_alu_i
                   & bus.alu_mismatch_i & ~faulty_q;
        tick     = bus.alu_valid_i & monitor & (decay_q == DECAY_LAST);
        trip     = '0;
        decay_d  = decay_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            trip[i]  = counted[i] & (cnt_q[i] == THRESH_M1);
            // A mismatch on the tick cycle wins: increment only, no decay
            if (counted[i]) begin
                if (cnt_q[i] != THRESH_C) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (tick && !faulty_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        faulty_d = faulty_q | trip;
        // Decay counter only advances on valid ops while monitoring
        if (bus.alu_valid_i && monitor) begin
            decay_d = tick ? '0 : decay_q + DW'(1);
        end
    end

    // Next-state logic for the MONITOR / RECONFIG / FATAL controller
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        event_d = |trip;
        unique case (state_q)
            ST_MONITOR: begin
                if (|trip) begin
                    if (popcount4(faulty_d) >= 3'd2) begin
                        state_d = ST_FATAL;
                    end else begin
                        state_d = ST_RECONFIG;
                        timer_d = RECONF_LAST;
                    end
                end
            end
            ST_RECONFIG: begin
                if (timer_q == '0) begin
                    state_d = ST_MONITOR;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_FATAL: begin
                state_d = ST_FATAL;
            end
            default: begin
                state_d = ST_MONITOR;
            end
        endcase
    end

    // State registers; software clear behaves exactly like reset
    always_ff @(posedge clk) begin
        if (rst || bus.clear_i) begin
            state_q  <= ST_MONITOR;
            faulty_q <= '0;
            decay_q  <= '0;
            timer_q  <= '0;
            event_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            faulty_q <= faulty_d;
            decay_q  <= decay_d;
            timer_q  <= timer_d;
            event_q  <= event_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // reconfig_o rises together with the new faulty bit because both come
    // from registers loaded on the same edge
    assign bus.permanent_faulty_alu_o = faulty_q;
    assign bus.reconfig_o             = (state_q == ST_RECONFIG);
    assign bus.fatal_o                = (state_q == ST_FATAL);
    assign bus.fault_event_o          = event_q;

endmodule
